// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: press-request port plus column-drive/row-sense lines of the emulated keypad.
interface keypad_emulator_if #(parameter int HOLD_W = 16);
   logic [3:0] col, row, key_code;
   logic req_valid, req_ready, contact, busy, done;
   logic [HOLD_W-1:0] hold_cycles;
   modport master (
      output col, req_valid, key_code, hold_cycles,
      input row, req_ready, contact, busy, done
   );
   modport slave (
      input col, req_valid, key_code, hold_cycles,
      output row, req_ready, contact, busy, done
   );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad responder with queued press/hold/release/gap sequencing.
// Define KEYPAD_BOUNCE_EN to build the LFSR-driven press and release bounce states.
module keypad_emulator #(
   parameter int HOLD_W = 16,
   parameter int BOUNCE_CYCLES = 8,
   parameter int GAP_CYCLES = 4
) (
   input logic clock,
   input logic reset,
   keypad_emulator_if.slave kp
);
   localparam int BW = $clog2(BOUNCE_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int CW = HOLD_W > BW ? (HOLD_W > GW ? HOLD_W : GW) : (BW > GW ? BW : GW);
   localparam logic [CW-1:0] G_LD = GAP_CYCLES == 0 ? '0 : CW'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
   typedef enum logic [2:0] {IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif
   localparam state_t AFTER = GAP_CYCLES == 0 ? IDLE : GAP;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n, hold_ld;
   logic [3:0] key;
   logic accept, last, contact_c, done_n, done_q;
   assign accept = state == IDLE && kp.req_valid;
   assign last = cnt == '0;
`ifdef KEYPAD_BOUNCE_EN
   localparam logic [CW-1:0] B_LD = CW'(BOUNCE_CYCLES - 1);
   logic [7:0] lfsr;
   logic [HOLD_W-1:0] hold_q;
   assign hold_ld = hold_q == '0 ? '0 : CW'(hold_q - HOLD_W'(1));
   always_ff @(posedge clock)
      if (reset) begin
         lfsr <= 8'hA5;
         hold_q <= '0;
      end else begin
         if (state == PRESS_BOUNCE || state == RELEASE_BOUNCE)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (accept) hold_q <= kp.hold_cycles;
      end
`else
   // Without bounce the hold count loads straight from the request on accept.
   assign hold_ld = kp.hold_cycles == '0 ? '0 : CW'(kp.hold_cycles - HOLD_W'(1));
`endif
   always_ff @(posedge clock)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         key <= '0;
         done_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         done_q <= done_n;
         if (accept) key <= kp.key_code;
      end
   always_comb begin
      state_n = state;
      cnt_n = (last || state == IDLE) ? cnt : cnt - CW'(1);
      done_n = 1'b0;
      contact_c = 1'b0;
      case (state)
         IDLE: if (accept) begin
`ifdef KEYPAD_BOUNCE_EN
            state_n = PRESS_BOUNCE;
            cnt_n = B_LD;
`else
            state_n = HOLD;
            cnt_n = hold_ld;
`endif
         end
`ifdef KEYPAD_BOUNCE_EN
         PRESS_BOUNCE: begin
            contact_c = lfsr[0];
            if (last) begin
               state_n = HOLD;
               cnt_n = hold_ld;
            end
         end
         RELEASE_BOUNCE: begin
            contact_c = lfsr[0];
            if (last) begin
               state_n = AFTER;
               cnt_n = G_LD;
               done_n = GAP_CYCLES == 0;
            end
         end
`endif
         HOLD: begin
            contact_c = 1'b1;
            if (last) begin
`ifdef KEYPAD_BOUNCE_EN
               state_n = RELEASE_BOUNCE;
               cnt_n = B_LD;
`else
               state_n = AFTER;
               cnt_n = G_LD;
               done_n = GAP_CYCLES == 0;
`endif
            end
         end
         GAP: if (last) begin
            state_n = IDLE;
            done_n = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   assign kp.req_ready = state == IDLE;
   assign kp.busy = state != IDLE;
   assign kp.contact = contact_c;
   assign kp.done = done_q;
   assign kp.row = (contact_c && kp.col[key[1:0]]) ? 4'b0001 << key[3:2] : 4'b0000;
endmodule
